pht_update_buffer: RTL and testbench

Decoupling buffer between branch resolution in the integer pipes and the single free PHT write port of the global-history branch predictor. Each cycle it accepts up to two resolved conditional-branch updates, computes the new 2-bit saturating counter values, and merges same-index pairs. It then drains the results one per cycle to the predictor under a valid/ready handshake. This frees the predictor's second write port and keeps update bursts from being lost while the predictor's read/write ports are busy.

---
 rtl/pht_update_buffer_pkg.sv | 26 ++
 rtl/pht_update_buffer_queue_pointer.sv | 39 +++
 rtl/pht_update_buffer.sv | 115 +++++++++++
 tb/tb_pht_update_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pht_update_buffer_pkg.sv
// Shared fetch-unit types for the PHT update path: entry layout, counter
// widths and the saturating-counter update rule.
package FetchUnitTypes;

    localparam int PHT_UPDATE_BUF_SIZE = 32;
    localparam int PHT_INDEX_WIDTH     = 12;
    localparam int PHT_CTR_WIDTH       = 2;
    localparam int PHT_CTR_MAX         = (1 << PHT_CTR_WIDTH) - 1;

    typedef logic [PHT_INDEX_WIDTH-1:0] PhtIndexPath;
    typedef logic [PHT_CTR_WIDTH-1:0]   PhtEntryPath;

    typedef struct packed {
        PhtIndexPath index;
        PhtEntryPath value;
    } PhtUpdateEntry;

    // Taken moves the counter up, not-taken moves it down, clamped at both ends.
    function automatic PhtEntryPath PhtSatUpdate(input PhtEntryPath prev, input logic taken);
        if (taken)
            return (prev == PhtEntryPath'(PHT_CTR_MAX)) ? prev : prev + PhtEntryPath'(1);
        else
            return (prev == '0) ? prev : prev - PhtEntryPath'(1);
    endfunction

endpackage

// File: rtl/pht_update_buffer_queue_pointer.sv
// Head/tail/occupancy bookkeeping for a circular queue that can take up to
// two pushes and one pop per cycle.
module dual_push_queue_pointer #(
    parameter int ENTRY_NUM = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [1:0]                     pushNum,
    input  logic                           pop,
    output logic [$clog2(ENTRY_NUM)-1:0]   headPtr,
    output logic [$clog2(ENTRY_NUM)-1:0]   tailPtr,
    output logic [$clog2(ENTRY_NUM):0]     count,
    output logic [$clog2(ENTRY_NUM):0]     freeCount
);

    localparam int PTR_WIDTH = $clog2(ENTRY_NUM);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    // Pointers wrap naturally because ENTRY_NUM is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            headPtr <= headPtr + PTR_WIDTH'(pop);
            tailPtr <= tailPtr + PTR_WIDTH'(pushNum);
            count   <= count + CNT_WIDTH'(pushNum) - CNT_WIDTH'(pop);
        end
    end

    assign freeCount = CNT_WIDTH'(ENTRY_NUM) - count;

endmodule

// File: rtl/pht_update_buffer.sv
// Buffers up to two resolved branch updates per cycle and drains them one per
// cycle into the single free PHT write port.
module pht_update_buffer
    import FetchUnitTypes::*;
#(
    parameter int ENTRY_NUM   = PHT_UPDATE_BUF_SIZE,
    parameter int INDEX_WIDTH = PHT_INDEX_WIDTH,
    parameter int CTR_WIDTH   = PHT_CTR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           inValid [2],
    input  logic [INDEX_WIDTH-1:0]         inIndex [2],
    input  logic [CTR_WIDTH-1:0]           inPrev  [2],
    input  logic                           inTaken [2],
    output logic                           inReady,
    output logic                           outValid,
    output logic [INDEX_WIDTH-1:0]         outIndex,
    output logic [CTR_WIDTH-1:0]           outValue,
    input  logic                           outReady,
    output logic [$clog2(ENTRY_NUM):0]     count,
    output logic [15:0]                    dropCount
);

    localparam int PTR_WIDTH = $clog2(ENTRY_NUM);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [PTR_WIDTH-1:0] headPtr;
    logic [PTR_WIDTH-1:0] tailPtr;
    logic [CNT_WIDTH-1:0] freeCount;
    logic [CNT_WIDTH-1:0] space;
    logic [1:0]           pushNum;
    logic [1:0]           reqNum;
    logic [1:0]           dropNum;
    logic [16:0]          dropSum;
    logic                 pop;
    logic                 merge;
    PhtEntryPath          laneValue [2];
    PhtEntryPath          mergedValue;
    PhtUpdateEntry        pushEntry [2];
    PhtUpdateEntry        headEntry;
    PhtUpdateEntry        storage [ENTRY_NUM];

    dual_push_queue_pointer #(
        .ENTRY_NUM(ENTRY_NUM)
    ) queuePointer (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .pushNum  (pushNum),
        .pop      (pop),
        .headPtr  (headPtr),
        .tailPtr  (tailPtr),
        .count    (count),
        .freeCount(freeCount)
    );

    assign outValid = (count != '0);
    assign inReady  = (count <= CNT_WIDTH'(ENTRY_NUM - 2));
    assign pop      = outValid && outReady;

    // A same-index pair collapses into one entry: lane 1's direction is
    // applied on top of lane 0's already-updated counter.
    always_comb begin
        laneValue[0] = PhtSatUpdate(inPrev[0], inTaken[0]);
        laneValue[1] = PhtSatUpdate(inPrev[1], inTaken[1]);
        merge        = inValid[0] && inValid[1] && (inIndex[0] == inIndex[1]);
        mergedValue  = PhtSatUpdate(laneValue[0], inTaken[1]);

        pushEntry[0].index = inValid[0] ? inIndex[0] : inIndex[1];
        pushEntry[0].value = inValid[0] ? (merge ? mergedValue : laneValue[0]) : laneValue[1];
        pushEntry[1].index = inIndex[1];
        pushEntry[1].value = laneValue[1];

        reqNum = merge ? 2'd1 : ({1'b0, inValid[0]} + {1'b0, inValid[1]});
    end

    // Admission counts this cycle's pop as free space; lane 0 is taken first,
    // so a shortfall of one slot always drops lane 1.
    always_comb begin
        space   = freeCount + CNT_WIDTH'(pop);
        pushNum = 2'd0;
        dropNum = 2'd0;
        if (!flush) begin
            if (space >= CNT_WIDTH'(reqNum)) begin
                pushNum = reqNum;
            end else begin
                pushNum = space[1:0];
                dropNum = merge ? 2'd2 : (reqNum - space[1:0]);
            end
        end
        dropSum = {1'b0, dropCount} + 17'(dropNum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dropCount <= '0;
        else
            dropCount <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end

    // Storage needs no reset; the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (pushNum != 2'd0)
            storage[tailPtr] <= pushEntry[0];
        if (pushNum == 2'd2)
            storage[tailPtr + PTR_WIDTH'(1)] <= pushEntry[1];
    end

    assign headEntry = storage[headPtr];
    assign outIndex  = outValid ? headEntry.index : '0;
    assign outValue  = outValid ? headEntry.value : '0;

endmodule

// File: tb/tb_pht_update_buffer.sv
// Directed bench for pht_update_buffer with a queue-based reference model
// compared against the DUT on every falling clock edge.
module tb_pht_update_buffer;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inValid [2];
    logic [11:0] inIndex [2];
    logic [1:0]  inPrev  [2];
    logic        inTaken [2];
    logic        inReady;
    logic        outValid;
    logic [11:0] outIndex;
    logic [1:0]  outValue;
    logic        outReady = 1'b0;
    logic [5:0]  count;
    logic [15:0] dropCount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        int val;
    } ModelEntry;

    ModelEntry modelQ[$];
    int        modelDrops = 0;

    pht_update_buffer #(
        .ENTRY_NUM  (N),
        .INDEX_WIDTH(12),
        .CTR_WIDTH  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (inValid),
        .inIndex  (inIndex),
        .inPrev   (inPrev),
        .inTaken  (inTaken),
        .inReady  (inReady),
        .outValid (outValid),
        .outIndex (outIndex),
        .outValue (outValue),
        .outReady (outReady),
        .count    (count),
        .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    function automatic int satUpdate(input int prev, input int taken);
        if (taken != 0) return (prev + 1 > 3) ? 3 : prev + 1;
        return (prev - 1 < 0) ? 0 : prev - 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic addDrops(input int n);
        modelDrops = (modelDrops + n > 65535) ? 65535 : modelDrops + n;
    endtask

    // Reference model: a plain FIFO of {index, value} updated at each edge.
    initial begin
        int        space;
        bit        popNow;
        ModelEntry e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                modelQ.delete();
                modelDrops = 0;
            end else if (flush) begin
                modelQ.delete();
            end else begin
                popNow = (modelQ.size() != 0) && outReady;
                space  = N - modelQ.size() + (popNow ? 1 : 0);
                if (popNow) void'(modelQ.pop_front());
                if (inValid[0] && inValid[1] && inIndex[0] == inIndex[1]) begin
                    e.idx = int'(inIndex[0]);
                    e.val = satUpdate(satUpdate(int'(inPrev[0]), int'(inTaken[0])), int'(inTaken[1]));
                    if (space >= 1) modelQ.push_back(e);
                    else addDrops(2);
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (inValid[i]) begin
                            e.idx = int'(inIndex[i]);
                            e.val = satUpdate(int'(inPrev[i]), int'(inTaken[i]));
                            if (space > 0) begin
                                modelQ.push_back(e);
                                space--;
                            end else begin
                                addDrops(1);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("outValid", int'(outValid), (modelQ.size() != 0) ? 1 : 0);
            checkOutput("count", int'(count), modelQ.size());
            checkOutput("inReady", int'(inReady), (modelQ.size() <= N - 2) ? 1 : 0);
            checkOutput("dropCount", int'(dropCount), modelDrops);
            checkOutput("outIndex", int'(outIndex), (modelQ.size() != 0) ? modelQ[0].idx : 0);
            checkOutput("outValue", int'(outValue), (modelQ.size() != 0) ? modelQ[0].val : 0);
        end
    end

    // Drives one cycle of inputs, waits for the consuming edge, then idles lanes.
    task automatic applyStimulus(input bit v0, input int i0, input int p0, input bit t0,
                                 input bit v1, input int i1, input int p1, input bit t1,
                                 input bit rdy, input bit fl = 1'b0);
        inValid[0] = v0; inIndex[0] = 12'(i0); inPrev[0] = 2'(p0); inTaken[0] = t0;
        inValid[1] = v1; inIndex[1] = 12'(i1); inPrev[1] = 2'(p1); inTaken[1] = t1;
        outReady   = rdy;
        flush      = fl;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        inValid[1] = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic idleCycle(input bit rdy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        bit rdy;
        int n;
        for (int i = 0; i < 2; i++) begin
            inValid[i] = 1'b0; inIndex[i] = '0; inPrev[i] = '0; inTaken[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rstInReady", int'(inReady), 1);
        checkOutput("rstOutValid", int'(outValid), 0);
        checkOutput("rstOutIndex", int'(outIndex), 0);
        checkOutput("rstOutValue", int'(outValue), 0);
        checkOutput("rstCount", int'(count), 0);
        checkOutput("rstDropCount", int'(dropCount), 0);

        applyStimulus(1, 'h12A, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("singleValid", int'(outValid), 1);
        checkOutput("singleIndex", int'(outIndex), 'h12A);
        checkOutput("singleValue", int'(outValue), 2);
        checkOutput("singleCount", int'(count), 1);
        idleCycle(1);
        checkOutput("singleDrained", int'(count), 0);

        applyStimulus(1, 'h011, 3, 1, 1, 'h022, 0, 0, 0);
        checkOutput("satCount", int'(count), 2);
        checkOutput("satHeadIndex", int'(outIndex), 'h011);
        checkOutput("satHeadValue", int'(outValue), 3);
        idleCycle(1);
        checkOutput("satSecondIndex", int'(outIndex), 'h022);
        checkOutput("satSecondValue", int'(outValue), 0);
        idleCycle(1);

        applyStimulus(1, 'h040, 2, 1, 1, 'h040, 2, 1, 0);
        checkOutput("mergeCount", int'(count), 1);
        checkOutput("mergeIndex", int'(outIndex), 'h040);
        checkOutput("mergeValue", int'(outValue), 3);
        idleCycle(1);
        applyStimulus(1, 'h155, 2, 1, 1, 'h155, 1, 0, 0);
        checkOutput("mergeDownValue", int'(outValue), 2);
        idleCycle(1);

        for (int k = 0; k < 5; k++) applyStimulus(1, 'h200 + k, k % 4, k[0], 0, 0, 0, 0, 0);
        checkOutput("preResetCount", int'(count), 5);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstValid", int'(outValid), 0);
        checkOutput("asyncRstCount", int'(count), 0);
        checkOutput("asyncRstDrop", int'(dropCount), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1, 'h3FF, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("postRstIndex", int'(outIndex), 'h3FF);
        checkOutput("postRstValue", int'(outValue), 1);
        idleCycle(1);

        for (int k = 0; k < 16; k++)
            applyStimulus(1, 'h400 + 2 * k, 1, 1, 1, 'h401 + 2 * k, 1, 0, 0);
        checkOutput("fullCount", int'(count), 32);
        checkOutput("fullInReady", int'(inReady), 0);
        applyStimulus(1, 'h480, 2, 1, 1, 'h481, 2, 0, 0);
        checkOutput("overflowCount", int'(count), 32);
        checkOutput("overflowDrop", int'(dropCount), 2);
        applyStimulus(1, 'h490, 0, 1, 1, 'h490, 1, 1, 0);
        checkOutput("mergedDrop", int'(dropCount), 4);
        applyStimulus(1, 'h4A0, 3, 0, 0, 0, 0, 0, 1);
        checkOutput("fullPopPushCount", int'(count), 32);
        checkOutput("fullPopPushDrop", int'(dropCount), 4);

        repeat (25) idleCycle(1);
        checkOutput("preFlushCount", int'(count), 7);
        applyStimulus(1, 'h4B0, 1, 1, 1, 'h4B1, 1, 1, 1, 1);
        checkOutput("flushCount", int'(count), 0);
        checkOutput("flushDrop", int'(dropCount), 4);

        rdy = 1'b0;
        n   = 0;
        applyStimulus(1, 'h500 + n, n % 4, 1, 0, 0, 0, 0, rdy);
        n++;
        for (int k = 0; k < 19; k++) begin
            rdy = ~rdy;
            applyStimulus(1, 'h500 + n, n % 4, (n % 3) == 0, 1, 'h501 + n, (n + 1) % 4, (n % 3) != 0, rdy);
            n += 2;
        end
        rdy = ~rdy;
        applyStimulus(1, 'h500 + n, n % 4, 0, 0, 0, 0, 0, rdy);

        for (int c = 0; c < 100 && modelQ.size() != 0; c++) idleCycle(1);
        checkOutput("wrapDrainedCount", int'(count), 0);
        checkOutput("wrapDrainedValid", int'(outValid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
